// File: rtl/dma_read_engine.sv
// Avalon-MM read engine: fetches num_words consecutive words from src_addr
// into a show-ahead FIFO and streams them out over valid/ready.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; address/remaining latched on acceptance
// S_READ  | issuing reads while the FIFO has room, until rem reaches 0
// S_DRAIN | no reads; waits for the FIFO to empty, then pulses done
module dma_read_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] num_words,
  output logic        busy,
  output logic        done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          r_state;
  logic [31:0]     r_addr;
  logic [31:0]     r_rem;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_done;

  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic            w_unused;

  assign w_unused = ^src_addr[1:0];

  // Gated on registered occupancy only, so a stalled request cannot be withdrawn.
  assign avm_read    = (r_state == S_READ) && (r_count < CW'(FIFO_DEPTH));
  assign avm_address = r_addr;
  assign w_push      = avm_read && !avm_waitrequest;
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign out_data    = out_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign busy        = r_busy;
  assign done        = r_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_rem    <= 32'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_count <= w_count_nxt;
      if (r_done) r_busy <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= {src_addr[31:2], 2'b00};
            r_rem   <= num_words;
            r_busy  <= 1'b1;
            r_state <= (num_words == 32'd0) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (w_push) begin
            r_addr <= r_addr + 32'd4;
            r_rem  <= r_rem - 32'd1;
            if (r_rem == 32'd1) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Looking at next occupancy lets done land the cycle after the last pop.
          if (w_count_nxt == '0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_engine.sv
// Self-checking bench for dma_read_engine: random-stall Avalon slave, random
// backpressure, and a queue-based model of the expected address/data stream.
module tb_dma_read_engine;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] num_words = 32'd0;
  logic        busy, done, avm_read, out_valid;
  logic [31:0] avm_address, out_data;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        out_ready = 1'b0;

  dma_read_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit wait_en = 0, ready_rand = 0, ready_val = 1;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int n_rd, n_pop, n_done, last_pop_cyc, done_cyc;
  logic [31:0] last_rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory content: the word at byte address a is a>>2.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Avalon slave and downstream ready driver
  initial begin
    int stall;
    bit pending;
    stall = 0;
    pending = 0;
    forever begin
      @(negedge clk);
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
      if (!reset_n || !avm_read) begin
        pending = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1;
          stall = wait_en ? int'($urandom_range(0, 3)) : 0;
        end
        if (stall > 0) begin
          avm_waitrequest = 1'b1;
          avm_readdata = 32'hDEAD_BEEF;
          stall--;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = mem_word(avm_address);
          pending = 0;
        end
      end
    end
  end

  // Monitor: protocol hold, read-to-stream latency, scoreboard
  initial begin
    bit pv_read, pv_wait, comp_prev;
    logic [31:0] pv_addr;
    pv_read = 0; pv_wait = 0; comp_prev = 0; pv_addr = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        pv_read = 0; pv_wait = 0; comp_prev = 0;
      end else begin
        if (pv_read && pv_wait) begin
          check("avm_hold_read", avm_read, 1);
          check("avm_hold_addr", avm_address, pv_addr);
        end
        if (comp_prev) check("rd_to_stream_valid", out_valid, 1);
        comp_prev = avm_read && !avm_waitrequest;
        if (comp_prev) begin
          n_rd++;
          last_rd_addr = avm_address;
          check("read_expected", exp_addr.size() > 0, 1);
          if (exp_addr.size() > 0) check("read_addr", avm_address, exp_addr.pop_front());
        end
        if (out_valid && out_ready) begin
          n_pop++;
          last_pop_cyc = cyc;
          check("pop_expected", exp_data.size() > 0, 1);
          if (exp_data.size() > 0) check("pop_data", out_data, exp_data.pop_front());
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        pv_read = avm_read; pv_wait = avm_waitrequest; pv_addr = avm_address;
      end
    end
  end

  task automatic launch(input logic [31:0] src, input int n, output int c0);
    logic [31:0] base;
    base = {src[31:2], 2'b00};
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(base + 32'(4 * k));
      exp_data.push_back(mem_word(base + 32'(4 * k)));
    end
    n_rd = 0; n_pop = 0; n_done = 0;
    @(negedge clk);
    start = 1'b1; src_addr = src; num_words = 32'(n);
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    check("busy_after_start", busy, 1);
    check("read_after_start", avm_read, (n != 0));
  endtask

  task automatic wait_done(input int budget, input int n);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("done_seen", n_done > 0, 1);
    check("busy_in_done_cycle", busy, 1);
    check("words_out", n_pop, n);
    check("reads_issued", n_rd, n);
    check("exp_left", exp_data.size(), 0);
    if (n > 0) check("done_after_last_pop", done_cyc, last_pop_cyc + 1);
    @(negedge clk);
    #2;
    check("busy_after_done", busy, 0);
    check("done_one_pulse", n_done, 1);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_avm_read", avm_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_out_data", out_data, 0);
  endtask

  initial begin
    int c0, k;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;
    ready_val = 1;

    // basic transfer, zero wait states, full throughput
    launch(32'h0, 128, c0);
    wait_done(400, 128);
    check("basic_last_addr", last_rd_addr, 32'h1FC);
    check("basic_throughput", done_cyc - c0, 129);

    // backpressure: ready low for 20 cycles
    ready_val = 0;
    launch(32'h200, 64, c0);
    repeat (10) @(negedge clk);
    check("bp_read_dropped", avm_read, 0);
    check("bp_fifo_full_valid", out_valid, 1);
    repeat (9) @(negedge clk);
    ready_val = 1;
    wait_done(400, 64);

    // zero length
    launch(32'h50, 0, c0);
    wait_done(20, 0);
    check("zero_done_latency", done_cyc - c0, 1);

    // address wrap and misalignment
    launch(32'hFFFF_FFFC, 2, c0);
    wait_done(50, 2);
    check("wrap_last_addr", last_rd_addr, 32'h0);
    launch(32'h103, 3, c0);
    check("misalign_first_addr", avm_address, 32'h100);
    wait_done(50, 3);

    // random wait states and random backpressure, with a stray start mid-transfer
    wait_en = 1;
    ready_rand = 1;
    launch(32'h400, 24, c0);
    repeat (6) @(negedge clk);
    start = 1'b1; src_addr = 32'h9000; num_words = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(600, 24);
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(1, 40));
      launch($urandom, n, c0);
      wait_done(n * 16 + 50, n);
    end

    // reset mid-transfer
    wait_en = 0;
    ready_rand = 0;
    ready_val = 1;
    launch(32'h0, 128, c0);
    k = 0;
    while (n_pop < 10 && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("pre_reset_progress", n_pop >= 10, 1);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_addr.delete();
    exp_data.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_en = 1;
    ready_rand = 1;
    launch(32'h40, 8, c0);
    wait_done(200, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
